// File: rtl/ex_mem_skid.sv
// ex_mem_skid: 2-entry FIFO buffering execute-stage results for the memory stage
module ex_mem_skid #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [REG_W-1:0]  in_rd,
    input  logic              in_wen,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_wen,
    output logic [1:0]        count
);
    localparam int E_W = DATA_W + REG_W + 1;
    logic [E_W-1:0] mem [2];
    logic           wr_ptr, rd_ptr, push, pop;
    assign in_ready  = (count != 2'd2) && !flush;
    assign out_valid = (count != 2'd0) && !flush;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    // payload is forced to zero whenever the buffer is empty
    assign {out_data, out_rd, out_wen} = (count == 2'd0) ? '0 : mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {in_data, in_rd, in_wen};
                wr_ptr      <= !wr_ptr;
            end
            if (pop) rd_ptr <= !rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_ex_mem_skid.sv
// tb_ex_mem_skid: directed and scoreboarded checks of the execute-to-memory skid FIFO
module tb_ex_mem_skid;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, in_wen, flush, out_valid, out_ready, out_wen;
    logic [15:0] in_data, out_data;
    logic [2:0]  in_rd, out_rd;
    logic [1:0]  count;
    int          n_chk = 0, n_pass = 0;
    logic [19:0] q[$];
    int          mc;
    logic        pu, po;
    logic [19:0] exp_head;

    ex_mem_skid dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_rd(in_rd), .in_wen(in_wen), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_rd(out_rd), .out_wen(out_wen), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic [2:0] r, input logic w);
        in_valid = v;
        in_data  = d;
        in_rd    = r;
        in_wen   = w;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 16'h0, 3'd0, 1'b0);
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_payload", {out_data, out_rd, out_wen}, 0);

        drive(1'b1, 16'hF0F0, 3'd3, 1'b1);
        step();
        drive(1'b0, 16'h0, 3'd0, 1'b0);
        #1;
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, 16'hF0F0);
        chk("single_rd", out_rd, 3);
        chk("single_wen", out_wen, 1);
        chk("single_count", count, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #1;
        chk("drain_count", count, 0);
        chk("drain_payload", {out_data, out_rd, out_wen}, 0);

        drive(1'b1, 16'h8001, 3'd1, 1'b1); step();
        drive(1'b1, 16'h4002, 3'd2, 1'b0); step();
        drive(1'b1, 16'h5003, 3'd5, 1'b1);
        #1;
        chk("full_count", count, 2);
        chk("full_in_ready", in_ready, 0);
        step();
        drive(1'b0, 16'h0, 3'd0, 1'b0);
        #1;
        chk("held_count", count, 2);
        chk("stall_stable", out_data, 16'h8001);
        out_ready = 1'b1;
        #1;
        chk("order_first", out_data, 16'h8001);
        step();
        chk("order_second", out_data, 16'h4002);
        chk("order_second_wen", out_wen, 0);
        chk("freed_in_ready", in_ready, 1);
        chk("after_pop_count", count, 1);
        step();
        out_ready = 1'b0;
        #1;
        chk("no_third", count, 0);

        drive(1'b1, 16'h1111, 3'd4, 1'b1); step();
        drive(1'b1, 16'h2222, 3'd6, 1'b1); out_ready = 1'b1; step();
        drive(1'b0, 16'h0, 3'd0, 1'b0); out_ready = 1'b0;
        #1;
        chk("pushpop_count", count, 1);
        chk("pushpop_data", out_data, 16'h2222);
        out_ready = 1'b1; step(); out_ready = 1'b0;

        drive(1'b1, 16'hAAAA, 3'd1, 1'b1); step();
        drive(1'b1, 16'hBBBB, 3'd2, 1'b1); step();
        flush = 1'b1; drive(1'b1, 16'hCCCC, 3'd3, 1'b1); out_ready = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 0);
        chk("flush_out_valid", out_valid, 0);
        step();
        flush = 1'b0; drive(1'b0, 16'h0, 3'd0, 1'b0); out_ready = 1'b0;
        #1;
        chk("flush_count", count, 0);
        chk("flush_data", out_data, 0);
        chk("flush_out_valid_next", out_valid, 0);

        drive(1'b1, 16'h1234, 3'd1, 1'b1); step();
        drive(1'b1, 16'h5678, 3'd2, 1'b1); step();
        rst = 1'b1; step();
        rst = 1'b0; drive(1'b0, 16'h0, 3'd0, 1'b0);
        #1;
        chk("midrst_count", count, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);

        mc = 0;
        for (int i = 0; i < 1000; i++) begin
            drive(1'($urandom), 16'($urandom), 3'($urandom), 1'($urandom));
            out_ready = 1'($urandom);
            #1;
            exp_head = (mc == 0) ? 20'h0 : q[0];
            chk("rnd_count", count, mc);
            chk("rnd_in_ready", in_ready, mc != 2);
            chk("rnd_out_valid", out_valid, mc != 0);
            chk("rnd_head", {out_data, out_rd, out_wen}, exp_head);
            pu = in_valid && (mc != 2);
            po = out_ready && (mc != 0);
            if (pu) q.push_back({in_data, in_rd, in_wen});
            step();
            if (po) void'(q.pop_front());
            mc = q.size();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
